// File: rtl/seq_gen.sv
//------------------------------------------------------------------------------
// seq_gen
//
// Serial pattern generator. On an accepted start it transmits a 4-bit PATTERN
// MSB first on x, repeated 'reps' times, with an optional idle-low gap of
// GAP_LEN cycles between repetitions. It finishes with a single-cycle done
// pulse. The x output is intended to feed a serial sequence detector.
//
// Parameters
//    PATTERN    4-bit pattern to transmit, MSB first
//    GAP_LEN    idle-low cycles between repetitions (0..7, 0 = back-to-back)
//
// Ports
//    clk         input   single clock, all state changes on the rising edge
//    rst         input   synchronous active-high reset
//    start       input   burst request, sampled only in IDLE
//    reps        input   number of repetitions, sampled with start
//    abort       input   terminates a burst in progress (SHIFT or GAP)
//    x           output  registered serial pattern bit
//    x_valid     output  high on cycles where x carries a pattern bit
//    busy        output  high while in SHIFT or GAP
//    done        output  one-cycle pulse at burst completion
//    sent_count  output  complete patterns sent in the current or last burst
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module seq_gen #(
   parameter logic [3:0]  PATTERN = 4'b1011,
   parameter int unsigned GAP_LEN = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] reps,
   input  logic       abort,
   output logic       x,
   output logic       x_valid,
   output logic       busy,
   output logic       done,
   output logic [3:0] sent_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } state_t;

   // The gap counter counts down to zero, so it is loaded with one less than
   // the gap length; the zero-gap build never takes the GAP branch.
   localparam bit         HAS_GAP  = (GAP_LEN > 0);
   localparam logic [2:0] GAP_LOAD = HAS_GAP ? 3'(GAP_LEN - 1) : 3'd0;

   state_t     state_q;
   logic [1:0] bitIdx_q;
   logic [3:0] repsLeft_q;
   logic [2:0] gapCnt_q;
   logic [3:0] sentCount_q;
   logic       x_q;
   logic       xValid_q;
   logic       busy_q;
   logic       done_q;

   logic [1:0] bitIdx_d;
   logic       nextBit_d;
   logic       lastRep_d;

   // bitIdx_q is the index of the bit currently on x, so the bit to present
   // next cycle is the one just below it. lastRep_d flags that the pattern
   // finishing now is the final one of the burst.
   always_comb begin
      bitIdx_d  = bitIdx_q - 2'd1;
      nextBit_d = PATTERN[bitIdx_d];
      lastRep_d = (repsLeft_q == 4'd1);
   end

   // Single state machine with registered outputs. Every transition writes
   // the output registers for the state being entered, so x, x_valid, busy
   // and done line up with the state they describe. Abort is tested before
   // any completion logic so that it always wins over a done pulse and never
   // credits the pattern that was in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         bitIdx_q    <= 2'd0;
         repsLeft_q  <= 4'd0;
         gapCnt_q    <= 3'd0;
         sentCount_q <= 4'd0;
         x_q         <= 1'b0;
         xValid_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               x_q      <= 1'b0;
               xValid_q <= 1'b0;
               busy_q   <= 1'b0;
               done_q   <= 1'b0;
               if (start) begin
                  sentCount_q <= 4'd0;
                  if (reps != 4'd0) begin
                     repsLeft_q <= reps;
                     bitIdx_q   <= 2'd3;
                     x_q        <= PATTERN[3];
                     xValid_q   <= 1'b1;
                     busy_q     <= 1'b1;
                     state_q    <= SHIFT;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end

            SHIFT: begin
               if (abort) begin
                  x_q      <= 1'b0;
                  xValid_q <= 1'b0;
                  busy_q   <= 1'b0;
                  state_q  <= IDLE;
               end else if (bitIdx_q == 2'd0) begin
                  sentCount_q <= sentCount_q + 4'd1;
                  repsLeft_q  <= repsLeft_q - 4'd1;
                  if (lastRep_d) begin
                     x_q      <= 1'b0;
                     xValid_q <= 1'b0;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     state_q  <= DONE;
                  end else if (HAS_GAP) begin
                     x_q      <= 1'b0;
                     xValid_q <= 1'b0;
                     gapCnt_q <= GAP_LOAD;
                     state_q  <= GAP;
                  end else begin
                     bitIdx_q <= 2'd3;
                     x_q      <= PATTERN[3];
                  end
               end else begin
                  bitIdx_q <= bitIdx_d;
                  x_q      <= nextBit_d;
               end
            end

            GAP: begin
               if (abort) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (gapCnt_q == 3'd0) begin
                  bitIdx_q <= 2'd3;
                  x_q      <= PATTERN[3];
                  xValid_q <= 1'b1;
                  state_q  <= SHIFT;
               end else begin
                  gapCnt_q <= gapCnt_q - 3'd1;
               end
            end

            DONE: begin
               x_q      <= 1'b0;
               xValid_q <= 1'b0;
               busy_q   <= 1'b0;
               done_q   <= 1'b0;
               state_q  <= IDLE;
            end

            default: begin
               x_q      <= 1'b0;
               xValid_q <= 1'b0;
               busy_q   <= 1'b0;
               done_q   <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   assign x          = x_q;
   assign x_valid    = xValid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign sent_count = sentCount_q;

endmodule

// File: tb/tb_seq_gen.sv
//------------------------------------------------------------------------------
// tb_seq_gen
//
// Bench for seq_gen. Two instances are built: dut0 with GAP_LEN=0 and dut2
// with GAP_LEN=2, both with PATTERN=1011. Stimulus pushes the hand-derived
// expected bit stream and done records into queues; a monitor on the falling
// edge pops them whenever a DUT shows x_valid or done. Cycle-exact checks of
// specific outputs are made directly from the stimulus process.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_seq_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       start0;
   logic       start2;
   logic       abort;
   logic [3:0] reps;

   logic       x0, xv0, busy0, done0;
   logic [3:0] sc0;
   logic       x2, xv2, busy2, done2;
   logic [3:0] sc2;

   int compared   = 0;
   int mismatched = 0;

   bit expBits0[$];
   bit expBits2[$];
   int expDone0[$];
   int expDone2[$];

   logic [3:0] detShift;
   int         detBits;
   int         detCount;

   always #5 clk = ~clk;

   seq_gen #(.PATTERN(4'b1011), .GAP_LEN(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .reps(reps), .abort(abort),
      .x(x0), .x_valid(xv0), .busy(busy0), .done(done0), .sent_count(sc0)
   );

   seq_gen #(.PATTERN(4'b1011), .GAP_LEN(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .reps(reps), .abort(abort),
      .x(x2), .x_valid(xv2), .busy(busy2), .done(done2), .sent_count(sc2)
   );

   // One comparison: counts it and reports a FAIL line on any difference,
   // including X/Z on the DUT side.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Scoreboard pop for one DUT: a valid bit must match the head of the bit
   // queue, an invalid cycle must hold x low, and a done pulse must match the
   // head of the done queue (expected sent_count).
   task automatic monitorCheck(input int sel, input logic xv, input logic vld,
                               input logic dn, input logic [3:0] sc);
      bit eb;
      int ed;
      int qsize;
      if (vld === 1'b1) begin
         qsize = (sel == 0) ? expBits0.size() : expBits2.size();
         if (qsize == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_bit dut%0d: got x_valid=1, expected no bit", sel * 2);
         end else begin
            if (sel == 0) eb = expBits0.pop_front();
            else          eb = expBits2.pop_front();
            checkOutput((sel == 0) ? "stream_bit_dut0" : "stream_bit_dut2", xv, eb);
         end
         if (sel == 0) begin
            detShift = {detShift[2:0], xv};
            detBits++;
            if (detBits >= 4 && detShift == 4'b1011) detCount++;
         end
      end else begin
         checkOutput((sel == 0) ? "idle_x_dut0" : "idle_x_dut2", xv, 1'b0);
      end
      if (dn === 1'b1) begin
         qsize = (sel == 0) ? expDone0.size() : expDone2.size();
         if (qsize == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_done dut%0d: got done=1, expected no pulse", sel * 2);
         end else begin
            if (sel == 0) ed = expDone0.pop_front();
            else          ed = expDone2.pop_front();
            checkOutput((sel == 0) ? "done_count_dut0" : "done_count_dut2", sc, ed);
         end
      end
   endtask

   always @(negedge clk) begin
      monitorCheck(0, x0, xv0, done0, sc0);
      monitorCheck(1, x2, xv2, done2, sc2);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Push n copies of the 1011 pattern, MSB first, for the chosen DUT.
   task automatic pushPattern(input int sel, input int n);
      for (int k = 0; k < n; k++) begin
         if (sel == 0) begin
            expBits0.push_back(1'b1); expBits0.push_back(1'b0);
            expBits0.push_back(1'b1); expBits0.push_back(1'b1);
         end else begin
            expBits2.push_back(1'b1); expBits2.push_back(1'b0);
            expBits2.push_back(1'b1); expBits2.push_back(1'b1);
         end
      end
   endtask

   // Holds start for one cycle (cycle 0); returns at the start of cycle 1.
   task automatic applyStimulus(input int sel, input logic [3:0] r);
      reps = r;
      if (sel == 0) start0 = 1'b1;
      else          start2 = 1'b1;
      tick();
      start0 = 1'b0;
      start2 = 1'b0;
      reps   = 4'd0;
   endtask

   initial begin
      rst = 1'b1; start0 = 1'b0; start2 = 1'b0; abort = 1'b0; reps = 4'd0;
      detShift = 4'd0; detBits = 0; detCount = 0;
      tick(); tick();
      checkOutput("rst_x",      x0,    1'b0);
      checkOutput("rst_xvalid", xv0,   1'b0);
      checkOutput("rst_busy",   busy0, 1'b0);
      checkOutput("rst_done",   done0, 1'b0);
      checkOutput("rst_count",  sc0,   4'd0);
      checkOutput("rst_busy2",  busy2, 1'b0);
      checkOutput("rst_count2", sc2,   4'd0);
      rst = 1'b0;
      tick();

      // Single repetition: bits in cycles 1-4, done in cycle 5.
      pushPattern(0, 1); expDone0.push_back(1);
      applyStimulus(0, 4'd1);
      checkOutput("single_busy",   busy0, 1'b1);
      checkOutput("single_xvalid", xv0,   1'b1);
      repeat (4) tick();
      checkOutput("single_done",   done0, 1'b1);
      checkOutput("single_count",  sc0,   4'd1);
      tick();
      checkOutput("single_done_clear", done0, 1'b0);
      checkOutput("single_idle_busy",  busy0, 1'b0);

      // Three back-to-back repetitions: 101110111011, done in cycle 13.
      detShift = 4'd0; detBits = 0; detCount = 0;
      pushPattern(0, 3); expDone0.push_back(3);
      applyStimulus(0, 4'd3);
      repeat (11) tick();
      checkOutput("triple_predone", done0, 1'b0);
      tick();
      checkOutput("triple_done",  done0, 1'b1);
      checkOutput("triple_count", sc0,   4'd3);
      tick();
      checkOutput("triple_detect", detCount, 3);

      // Start with reps=5 while busy is ignored.
      pushPattern(0, 1); expDone0.push_back(1);
      applyStimulus(0, 4'd1);
      tick();
      reps = 4'd5; start0 = 1'b1;
      tick();
      start0 = 1'b0; reps = 4'd0;
      tick(); tick();
      checkOutput("busy_start_done",  done0, 1'b1);
      checkOutput("busy_start_count", sc0,   4'd1);
      tick();
      checkOutput("busy_start_idle", busy0, 1'b0);
      tick();

      // reps=0: done in cycle 1 with nothing sent.
      expDone0.push_back(0);
      applyStimulus(0, 4'd0);
      checkOutput("zero_done",  done0, 1'b1);
      checkOutput("zero_busy",  busy0, 1'b0);
      checkOutput("zero_count", sc0,   4'd0);
      tick();
      checkOutput("zero_done_clear", done0, 1'b0);

      // Abort in cycle 6 of a two-rep burst: second pattern sent 1,0 only.
      pushPattern(0, 1); expBits0.push_back(1'b1); expBits0.push_back(1'b0);
      applyStimulus(0, 4'd2);
      repeat (5) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("abort_busy",   busy0, 1'b0);
      checkOutput("abort_xvalid", xv0,   1'b0);
      checkOutput("abort_done",   done0, 1'b0);
      checkOutput("abort_count",  sc0,   4'd1);
      tick();
      checkOutput("abort_no_done", done0, 1'b0);

      // Abort on the final bit beats completion: no done pulse.
      pushPattern(0, 1);
      applyStimulus(0, 4'd1);
      repeat (3) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("abort_last_done", done0, 1'b0);
      checkOutput("abort_last_busy", busy0, 1'b0);
      tick();

      // Reset in cycle 3 discards the burst; a new burst is then clean.
      expBits0.push_back(1'b1); expBits0.push_back(1'b0); expBits0.push_back(1'b1);
      applyStimulus(0, 4'd2);
      tick(); tick();
      rst = 1'b1;
      tick();
      checkOutput("midrst_x",      x0,    1'b0);
      checkOutput("midrst_xvalid", xv0,   1'b0);
      checkOutput("midrst_busy",   busy0, 1'b0);
      checkOutput("midrst_done",   done0, 1'b0);
      checkOutput("midrst_count",  sc0,   4'd0);
      rst = 1'b0;
      tick();
      pushPattern(0, 1); expDone0.push_back(1);
      applyStimulus(0, 4'd1);
      repeat (4) tick();
      checkOutput("postrst_done",  done0, 1'b1);
      checkOutput("postrst_count", sc0,   4'd1);
      tick();

      // GAP_LEN=2, reps=2: 1011,gap,gap,1011, done in cycle 11.
      pushPattern(1, 2); expDone2.push_back(2);
      applyStimulus(1, 4'd2);
      repeat (4) tick();
      checkOutput("gap1_xvalid", xv2,   1'b0);
      checkOutput("gap1_busy",   busy2, 1'b1);
      tick();
      checkOutput("gap2_xvalid", xv2,   1'b0);
      checkOutput("gap2_busy",   busy2, 1'b1);
      tick();
      checkOutput("gap_resume_xvalid", xv2, 1'b1);
      repeat (4) tick();
      checkOutput("gap_done",  done2, 1'b1);
      checkOutput("gap_count", sc2,   4'd2);
      tick();

      // Abort during the gap of a three-rep burst.
      pushPattern(1, 1);
      applyStimulus(1, 4'd3);
      repeat (4) tick();
      checkOutput("gapabort_pre_busy", busy2, 1'b1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("gapabort_busy",   busy2, 1'b0);
      checkOutput("gapabort_xvalid", xv2,   1'b0);
      checkOutput("gapabort_done",   done2, 1'b0);
      checkOutput("gapabort_count",  sc2,   4'd1);
      tick();

      // Maximum burst of 15 repetitions: sent_count reaches 15 without wrap.
      pushPattern(0, 15); expDone0.push_back(15);
      applyStimulus(0, 4'd15);
      repeat (60) tick();
      checkOutput("max_done",  done0, 1'b1);
      checkOutput("max_count", sc0,   4'd15);
      repeat (3) tick();
      checkOutput("max_count_hold", sc0, 4'd15);

      checkOutput("left_bits_dut0", expBits0.size(), 0);
      checkOutput("left_bits_dut2", expBits2.size(), 0);
      checkOutput("left_done_dut0", expDone0.size(), 0);
      checkOutput("left_done_dut2", expDone2.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 SHALL have parameter PATTERN, default 4'b1011, giving the 4-bit pattern to transmit, MSB first.
REQ-002 SHALL have parameter GAP_LEN, default 0, giving the number of idle-low cycles between repetitions (0..7).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port reps  input  4  number of pattern repetitions in the burst; sampled with start.
REQ-007 SHALL have port abort  input  1  terminates a burst in progress.
REQ-008 SHALL have port x  output  1  serial pattern bit, registered; drives the detector's x input.
REQ-009 SHALL have port x_valid  output  1  high on cycles where x carries a pattern bit.
REQ-010 SHALL have port busy  output  1  high while in SHIFT or GAP.
REQ-011 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-012 SHALL have port sent_count  output  4  number of complete patterns sent in the current or last burst.

Function
REQ-013 SHALL implement the states IDLE, SHIFT, GAP and DONE.
REQ-014 SHALL, in IDLE with start=1 and reps!=0, latch reps, clear sent_count, clear the bit index to 3, and enter SHIFT.
REQ-015 SHALL, in IDLE with start=1 and reps=0, enter DONE without transmitting, leaving sent_count at 0.
REQ-016 SHALL, while in SHIFT, drive x=PATTERN[index] and x_valid=1, so the first bit appears the cycle after start is accepted.
REQ-017 SHALL, while in SHIFT, decrement the index each cycle; at index 0 it SHALL increment sent_count and decrement the remaining-rep counter.
REQ-018 SHALL, at index 0 with repetitions remaining, go to GAP if GAP_LEN>0, else reload index 3 and stay in SHIFT so patterns are back-to-back.
REQ-019 SHALL, at index 0 of the last repetition, enter DONE.
REQ-020 SHALL, in GAP, drive x=0 and x_valid=0 for exactly GAP_LEN cycles, then return to SHIFT with index 3.
REQ-021 SHALL, in DONE, assert done=1 for exactly one cycle with x=0 and x_valid=0, then return to IDLE.
REQ-022 SHALL, in IDLE and DONE, hold x=0, x_valid=0 and busy=0.
REQ-023 SHALL ignore start while busy=1 or in DONE, with no effect on the latched reps.
REQ-024 SHALL, on abort=1 in SHIFT or GAP, enter IDLE next cycle with x=0, x_valid=0, done not asserted, and sent_count holding completed patterns only.
REQ-025 SHALL ignore abort in IDLE and DONE.
REQ-026 SHALL give abort priority over burst completion in the same cycle, so no done pulse is produced.
REQ-027 SHALL hold sent_count after a burst until the next accepted start; the maximum value of 15 fits without wrap.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, enter IDLE and set x=0, x_valid=0, busy=0, done=0 and sent_count=0, with the internal counters cleared.
REQ-029 SHALL give rst priority over start and abort, and SHALL discard any burst in progress mid-operation without a done pulse.

Verification
REQ-030 SHALL be verified with PATTERN=1011, GAP_LEN=0, start with reps=1 at cycle 0 -> x=1,0,1,1 with x_valid=1 in cycles 1-4; done=1 in cycle 5; sent_count=1.
REQ-031 SHALL be verified with reps=3, GAP_LEN=0, x fed to the sequence detector/counter -> serial stream 101110111011; done at cycle 13; sent_count=3; detector count=3.
REQ-032 SHALL be verified with GAP_LEN=2, reps=2 -> 1011,0,0,1011 with x_valid low in the two gap cycles; done at cycle 11; sent_count=2.
REQ-033 SHALL be verified with start and reps=5 pulsed at cycle 2 of a reps=1 burst -> ignored; exactly 4 bits sent; sent_count=1.
REQ-034 SHALL be verified with reps=0 -> done in cycle 1; x_valid never high; sent_count=0.
REQ-035 SHALL be verified with abort in cycle 6 of a reps=2 burst -> IDLE in cycle 7; no done pulse; sent_count=1.
REQ-036 SHALL be verified with rst in cycle 3 of a burst -> all outputs 0 the next cycle; a new start then produces a clean burst.
